// File: rtl/loom_scan_controller.sv
// Command-driven scan-chain controller: CAPTURE shifts the chain into a parallel register, RESTORE shifts it back out.
// Optional build macro LOOM_SCAN_RECIRC_EN feeds scan_out back into scan_in during CAPTURE, so capture does not destroy chain state.
module loom_scan_controller #(
  parameter int DataWidth  = 64,
  parameter int CountWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  input  logic [2:0]            cmd_i,
  input  logic [CountWidth-1:0] shift_count_i,
  input  logic [DataWidth-1:0]  shift_data_i,
  output logic [DataWidth-1:0]  shift_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  scan_enable_o,
  output logic                  scan_in_o,
  input  logic                  scan_out_i
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [2:0] CmdCapture = 3'd1;
  localparam logic [2:0] CmdRestore = 3'd2;

  logic [1:0]            state_q, state_d;
  logic                  restore_q, restore_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [DataWidth-1:0]  data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  scan_en_q, scan_en_d;
  logic                  scan_in_q, scan_in_d;

  always_comb begin
    state_d   = state_q;
    restore_d = restore_q;
    count_d   = count_q;
    data_d    = data_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid_i && (cmd_i == CmdCapture || cmd_i == CmdRestore)) begin
          restore_d = (cmd_i == CmdRestore);
          count_d   = shift_count_i;
          data_d    = (cmd_i == CmdRestore) ? shift_data_i : '0;
          state_d   = (shift_count_i == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        // Each edge spent here is exactly one chain shift on the DUT side.
        count_d = count_q - CountWidth'(1);
        data_d  = restore_q ? {data_q[DataWidth-2:0], 1'b0}
                            : {data_q[DataWidth-2:0], scan_out_i};
        if (count_q == CountWidth'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the next state so they line up with the shift cycles.
    busy_d    = (state_d == StShift);
    scan_en_d = (state_d == StShift);
    done_d    = (state_d == StDone);
    scan_in_d = (state_d == StShift) && restore_d && data_d[DataWidth-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      restore_q <= 1'b0;
      count_q   <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scan_en_q <= 1'b0;
      scan_in_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      restore_q <= restore_d;
      count_q   <= count_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scan_en_q <= scan_en_d;
      scan_in_q <= scan_in_d;
    end
  end

  assign shift_data_o  = data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign scan_enable_o = scan_en_q;

`ifdef LOOM_SCAN_RECIRC_EN
  // Tail feeds head during CAPTURE so a full-length capture rotates the chain back to its start.
  assign scan_in_o = (state_q == StShift && !restore_q) ? scan_out_i : scan_in_q;
`else
  assign scan_in_o = scan_in_q;
`endif

endmodule

// File: tb/tb_loom_scan_controller.sv
// Bench for loom_scan_controller: a 50-bit scan chain with two embedded counters, a transaction-level output model, and directed checks.
module tb_loom_scan_controller;

  localparam int DW = 64;
  localparam int L  = 50;
  localparam logic [49:0] INIT = 50'h2_5A3C_9F01_7E6D;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic [15:0] shift_count = 16'd0;
  logic [63:0] shift_data = 64'd0;
  logic [63:0] shift_data_o;
  logic        busy_o, done_o, scan_enable_o, scan_in_o, scan_out;

  logic [49:0] chain = INIT;
  logic        chain_clr = 1'b0;
  logic        cnt_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  loom_scan_controller #(.DataWidth(64), .CountWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid), .cmd_i(cmd),
    .shift_count_i(shift_count), .shift_data_i(shift_data), .shift_data_o(shift_data_o),
    .busy_o(busy_o), .done_o(done_o), .scan_enable_o(scan_enable_o),
    .scan_in_o(scan_in_o), .scan_out_i(scan_out)
  );

  // Emulated scan-inserted design: count_a in chain[7:0], count_b in chain[32:17].
  assign scan_out = chain[49];
  always @(posedge clk) begin
    if (scan_enable_o) chain <= {chain[48:0], scan_in_o};
    else if (chain_clr) begin
      chain[7:0]   <= 8'd0;
      chain[32:17] <= 16'd0;
    end else if (cnt_en) begin
      chain[7:0]   <= chain[7:0] + 8'd1;
      chain[32:17] <= chain[32:17] + 16'd1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit stream seen at the chain tail: chain[L-1] first, then zeros (or the rotated chain when recirculating).
  function automatic logic [63:0] cap_model(input logic [49:0] ch, input int n);
    logic [63:0] d;
    logic b;
    d = '0;
    for (int j = 0; j < n; j++) begin
`ifdef LOOM_SCAN_RECIRC_EN
      b = ch[L-1-(j % L)];
`else
      b = (j < L) ? ch[L-1-j] : 1'b0;
`endif
      d = {d[62:0], b};
    end
    return d;
  endfunction

  // Transaction model: cycle index k since the accepting edge; shift cycles 1..n, done at n+1.
  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_n = 0;
  bit          m_rest = 1'b0;
  logic [63:0] m_rd = '0;
  logic [63:0] m_data = '0;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_active = 1'b0;
      m_k      = 0;
      m_data   = '0;
    end else if (m_active) begin
      if (m_k == m_n + 1) begin
        m_active = 1'b0;
        m_k      = 0;
      end else m_k++;
    end else if (cmd_valid && (cmd == 3'd1 || cmd == 3'd2)) begin
      m_active = 1'b1;
      m_k      = 1;
      m_n      = int'(shift_count);
      m_rest   = (cmd == 3'd2);
      m_rd     = shift_data;
      if (m_rest) m_data = (m_n >= DW) ? 64'd0 : (shift_data << m_n);
      else        m_data = cap_model(chain, m_n);
    end
  end

  always @(negedge clk) begin
    logic eb, ed, ei;
    eb = m_active && (m_k <= m_n);
    ed = m_active && (m_k == m_n + 1);
    ei = 1'b0;
    if (eb && m_rest) ei = (m_k <= DW) ? m_rd[DW-m_k] : 1'b0;
`ifdef LOOM_SCAN_RECIRC_EN
    else if (eb) ei = chain[49];
`endif
    chk("busy", busy_o, eb);
    chk("scan_enable", scan_enable_o, eb);
    chk("done", done_o, ed);
    chk("scan_in", scan_in_o, ei);
    if (!eb) chk("shift_data", shift_data_o, m_data);
  end

  task automatic run_cmd(input logic [2:0] c, input int n, input logic [63:0] d, output int lat);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; shift_count = n[15:0]; shift_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!done_o && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!done_o) chk("done_timeout", done_o, 1);
  endtask

  initial begin
    int lat;
    int t;
    logic [63:0] cap;
    logic [49:0] exp_chain;
    exp_chain = INIT;
    exp_chain[7:0]   = 8'd100;
    exp_chain[32:17] = 16'd100;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_scan_en", scan_enable_o, 0);
    chk("rst_scan_in", scan_in_o, 0);
    chk("rst_data", shift_data_o, 0);
    rst_ni = 1'b1;

    chain_clr = 1'b1;
    @(negedge clk);
    chain_clr = 1'b0;
    cnt_en = 1'b1;
    repeat (100) @(negedge clk);
    cnt_en = 1'b0;

    run_cmd(3'd1, 50, 64'd0, lat);
    chk("cap50_latency", 64'(lat), 51);
    chk("cap50_count_a", shift_data_o[7:0], 100);
    chk("cap50_count_b", shift_data_o[32:17], 100);
    chk("cap50_chain", shift_data_o[49:0], exp_chain);
    cap = shift_data_o;
`ifdef LOOM_SCAN_RECIRC_EN
    chk("recirc_chain_kept", chain, exp_chain);
    run_cmd(3'd1, 50, 64'd0, lat);
    chk("recirc_second_cap", shift_data_o[49:0], exp_chain);
    chk("recirc_chain_kept2", chain, exp_chain);
`else
    chk("zero_fill_chain", chain, 0);
`endif

    chain_clr = 1'b1;
    @(negedge clk);
    chain_clr = 1'b0;
    run_cmd(3'd2, 50, cap << 14, lat);
    chk("rest50_latency", 64'(lat), 51);
    chk("rest_count_a", chain[7:0], 100);
    chk("rest_count_b", chain[32:17], 100);
    chk("rest_chain", chain, exp_chain);

    cnt_en = 1'b1;
    repeat (10) @(negedge clk);
    cnt_en = 1'b0;
    chk("run_count_a", chain[7:0], 110);
    chk("run_count_b", chain[32:17], 110);

    run_cmd(3'd1, 0, 64'd0, lat);
    chk("cap0_latency", 64'(lat), 1);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd = (i < 2) ? 3'd0 : 3'd5;
      shift_count = 16'd8;
      @(negedge clk);
      chk("nop_busy", busy_o, 0);
      chk("nop_done", done_o, 0);
    end
    cmd_valid = 1'b0;

    // Commands held during SHIFT and DONE must be dropped.
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd1; shift_count = 16'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd2; shift_data = '1; shift_count = 16'd3;
    t = 0;
    while (!done_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b0;
    chk("ignore_done", done_o, 1);
    @(negedge clk);
    chk("ignore_idle_busy", busy_o, 0);

    run_cmd(3'd1, 70, 64'd0, lat);
    chk("cap70_latency", 64'(lat), 71);
    run_cmd(3'd2, 70, 64'hDEAD_BEEF_0123_4567, lat);
    chk("rest70_data_exhausted", shift_data_o, 0);

    // Reset in the middle of a capture.
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd1; shift_count = 16'd50;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("abort_scan_en", scan_enable_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    @(negedge clk);
    chk("abort_no_done", done_o, 0);
    rst_ni = 1'b1;

    run_cmd(3'd1, 50, 64'd0, lat);
    chk("post_abort_latency", 64'(lat), 51);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
